// File: rtl/x_adc_interleave_mux.sv
// N-channel interleaving mux for time-interleaved ADC streams: manual select or
// round-robin over an enable mask, with registered sample, channel tag and frame marker.
module x_adc_interleave_mux #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     GlobalReset,
    input  logic [NUM_CH*DATA_W-1:0] x_adc_in,
    input  logic                     sample_strobe,
    input  logic                     mode,
    input  logic [CH_W-1:0]          x_adc_select,
    input  logic [NUM_CH-1:0]        ch_enable,
    output logic [DATA_W-1:0]        x_adc,
    output logic                     x_adc_valid,
    output logic [CH_W-1:0]          x_adc_ch,
    output logic                     frame_start,
    output logic                     no_ch_err
);

    logic [DATA_W-1:0] ch_data [NUM_CH];
    logic [CH_W-1:0]   ptr;
    logic [CH_W-1:0]   auto_sel;
    logic [CH_W-1:0]   first_en;
    logic              auto_found;

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            ch_data[k] = x_adc_in[k*DATA_W +: DATA_W];
        end
    end

    // Cyclic search from ptr relies on CH_W-bit addition wrapping at NUM_CH (power of 2).
    always_comb begin
        auto_sel   = ptr;
        auto_found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!auto_found && ch_enable[ptr + CH_W'(i)]) begin
                auto_sel   = ptr + CH_W'(i);
                auto_found = 1'b1;
            end
        end
    end

    always_comb begin
        first_en = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_enable[i]) begin
                first_en = CH_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            x_adc       <= ch_data[0];
            x_adc_valid <= 1'b0;
            x_adc_ch    <= '0;
            frame_start <= 1'b0;
            no_ch_err   <= 1'b0;
            ptr         <= '0;
        end else begin
            x_adc_valid <= 1'b0;
            frame_start <= 1'b0;
            if (!mode) begin
                // Parking ptr at 0 makes the first auto sample start a fresh frame.
                ptr <= '0;
                if (sample_strobe) begin
                    x_adc       <= ch_data[x_adc_select];
                    x_adc_ch    <= x_adc_select;
                    x_adc_valid <= 1'b1;
                end
            end else if (sample_strobe) begin
                if (auto_found) begin
                    x_adc       <= ch_data[auto_sel];
                    x_adc_ch    <= auto_sel;
                    x_adc_valid <= 1'b1;
                    frame_start <= (auto_sel == first_en);
                    ptr         <= auto_sel + CH_W'(1);
                end else begin
                    no_ch_err   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_x_adc_interleave_mux.sv
// Self-checking bench for x_adc_interleave_mux: directed scenarios then random
// traffic, all compared against a behavioural model of the channel selection rules.
module tb_x_adc_interleave_mux;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 32;
    localparam int CH_W   = 2;

    logic                     clk = 1'b0;
    logic                     GlobalReset;
    logic [NUM_CH*DATA_W-1:0] x_adc_in;
    logic                     sample_strobe;
    logic                     mode;
    logic [CH_W-1:0]          x_adc_select;
    logic [NUM_CH-1:0]        ch_enable;
    logic [DATA_W-1:0]        x_adc;
    logic                     x_adc_valid;
    logic [CH_W-1:0]          x_adc_ch;
    logic                     frame_start;
    logic                     no_ch_err;

    int n_checks = 0;
    int n_pass   = 0;

    int          m_ptr;
    logic [31:0] m_x;
    logic        m_valid;
    int          m_ch;
    logic        m_fs;
    logic        m_err;

    x_adc_interleave_mux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .GlobalReset  (GlobalReset),
        .x_adc_in     (x_adc_in),
        .sample_strobe(sample_strobe),
        .mode         (mode),
        .x_adc_select (x_adc_select),
        .ch_enable    (ch_enable),
        .x_adc        (x_adc),
        .x_adc_valid  (x_adc_valid),
        .x_adc_ch     (x_adc_ch),
        .frame_start  (frame_start),
        .no_ch_err    (no_ch_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] chan(input logic [NUM_CH*DATA_W-1:0] v, input int k);
        return v[k*DATA_W +: DATA_W];
    endfunction

    // Reference behaviour for one clock edge, using the inputs held across that edge.
    task automatic model_step();
        int s;
        int low;
        if (GlobalReset) begin
            m_x = chan(x_adc_in, 0); m_valid = 0; m_ch = 0; m_fs = 0; m_err = 0; m_ptr = 0;
        end else begin
            m_valid = 0;
            m_fs    = 0;
            if (mode == 1'b0) begin
                m_ptr = 0;
                if (sample_strobe) begin
                    m_x = chan(x_adc_in, int'(x_adc_select));
                    m_ch = int'(x_adc_select);
                    m_valid = 1;
                end
            end else if (sample_strobe) begin
                if (ch_enable == '0) begin
                    m_err = 1;
                end else begin
                    s = -1;
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (s < 0 && ch_enable[(m_ptr + k) % NUM_CH]) s = (m_ptr + k) % NUM_CH;
                    end
                    low = -1;
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (low < 0 && ch_enable[c]) low = c;
                    end
                    m_x = chan(x_adc_in, s);
                    m_ch = s;
                    m_valid = 1;
                    m_fs = (s == low);
                    m_ptr = (s + 1) % NUM_CH;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".x_adc"}, x_adc, m_x);
        check({tag, ".valid"}, {31'd0, x_adc_valid}, {31'd0, m_valid});
        check({tag, ".ch"}, {30'd0, x_adc_ch}, 32'(m_ch));
        check({tag, ".frame_start"}, {31'd0, frame_start}, {31'd0, m_fs});
        check({tag, ".no_ch_err"}, {31'd0, no_ch_err}, {31'd0, m_err});
    endtask

    task automatic applyStimulus(input logic rst, input logic str, input logic md,
                                 input logic [CH_W-1:0] sel, input logic [NUM_CH-1:0] en,
                                 input string tag);
        GlobalReset   = rst;
        sample_strobe = str;
        mode          = md;
        x_adc_select  = sel;
        ch_enable     = en;
        @(posedge clk);
        model_step();
        #1;
        checkOutput(tag);
    endtask

    initial begin
        int exp_seq [6];
        int exp_fs  [6];
        exp_seq = '{0, 1, 2, 3, 0, 1};
        exp_fs  = '{1, 0, 0, 0, 1, 0};
        m_ptr = 0; m_x = '0; m_valid = 0; m_ch = 0; m_fs = 0; m_err = 0;
        for (int k = 0; k < NUM_CH; k++) x_adc_in[k*DATA_W +: DATA_W] = 32'hA000_0000 + 32'(k);
        GlobalReset = 1; sample_strobe = 0; mode = 0; x_adc_select = 0; ch_enable = '0;
        #1;

        applyStimulus(1, 0, 0, 0, 4'b0000, "reset1");
        applyStimulus(1, 0, 0, 0, 4'b0000, "reset2");
        check("reset.x_adc_const", x_adc, 32'hA000_0000);
        check("reset.valid_const", {31'd0, x_adc_valid}, 32'd0);

        applyStimulus(0, 1, 0, 2, 4'b0000, "manual");
        check("manual.x_adc_const", x_adc, 32'hA000_0002);
        check("manual.ch_const", {30'd0, x_adc_ch}, 32'd2);
        applyStimulus(0, 0, 0, 2, 4'b0000, "manual_hold");
        check("manual_hold.x_adc_const", x_adc, 32'hA000_0002);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1, 1, 0, 4'b1111, "auto_all");
            check("auto_all.seq", {30'd0, x_adc_ch}, 32'(exp_seq[i]));
            check("auto_all.fs_seq", {31'd0, frame_start}, 32'(exp_fs[i]));
        end

        applyStimulus(0, 0, 0, 0, 4'b1010, "park1");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 1, 0, 4'b1010, "auto_sparse");
            check("auto_sparse.seq", {30'd0, x_adc_ch}, (i % 2 == 0) ? 32'd1 : 32'd3);
        end

        applyStimulus(0, 0, 0, 0, 4'b1111, "park2");
        applyStimulus(0, 1, 1, 0, 4'b1111, "mask_chg0");
        applyStimulus(0, 1, 1, 0, 4'b1111, "mask_chg1");
        applyStimulus(0, 1, 1, 0, 4'b0101, "mask_chg2");
        check("mask_chg.seq2", {30'd0, x_adc_ch}, 32'd2);
        applyStimulus(0, 1, 1, 0, 4'b0101, "mask_chg3");
        check("mask_chg.seq0", {30'd0, x_adc_ch}, 32'd0);
        check("mask_chg.fs0", {31'd0, frame_start}, 32'd1);
        applyStimulus(0, 1, 1, 0, 4'b0101, "mask_chg4");

        applyStimulus(0, 1, 1, 0, 4'b0000, "no_ch");
        check("no_ch.err_const", {31'd0, no_ch_err}, 32'd1);
        applyStimulus(0, 1, 1, 0, 4'b1111, "resume");
        applyStimulus(1, 1, 1, 0, 4'b1111, "rst_mid");
        check("rst_mid.valid_const", {31'd0, x_adc_valid}, 32'd0);
        applyStimulus(0, 1, 1, 0, 4'b1111, "post_rst");
        check("post_rst.ch_const", {30'd0, x_adc_ch}, 32'd0);

        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < NUM_CH; k++) x_adc_in[k*DATA_W +: DATA_W] = $urandom;
            applyStimulus(($urandom_range(0, 49) == 0),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 4) != 0),
                          CH_W'($urandom_range(0, NUM_CH - 1)),
                          ($urandom_range(0, 9) == 0) ? 4'b0000 : NUM_CH'($urandom),
                          "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
